// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 hex keypad scanner.
// Frame bit index is row*4+col; codes follow the Pmod KYPD legend.
package keypad_pkg;

    localparam int FRAME_W = 16;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_HELD,
        ST_MULTI
    } key_state_e;

    localparam logic [3:0] KEY_MAP [FRAME_W] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    localparam logic [3:0] COL_SEL [4] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: commits a keypad state after a run of identical
// frames and classifies it as released, single key or multiple keys.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_end,
    input  logic [FRAME_W-1:0] frame,
    output logic [3:0]         key,
    output logic               key_valid,
    output logic               key_strobe,
    output logic               multi
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    key_state_e         state_q, state_d;
    logic [FRAME_W-1:0] prev_q, prev_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         key_q, key_d;
    logic               strobe_q, strobe_d;
    logic               commit;
    logic [4:0]         ones;
    logic [3:0]         idx;
    logic [3:0]         code;

    assign ones = 5'($countones(frame));

    always_comb begin
        idx = 4'd0;
        for (int i = 0; i < FRAME_W; i++) begin
            if (frame[i]) idx = 4'(i);
        end
    end

    assign code = KEY_MAP[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RELEASED;
            prev_q   <= '0;
            cnt_q    <= '0;
            key_q    <= 4'h0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        strobe_d = 1'b0;
        commit   = 1'b0;
        if (frame_end) begin
            prev_d = frame;
            if (frame == prev_q) begin
                // Commit only on the transition into saturation.
                if (cnt_q != CW'(DEBOUNCE_FRAMES)) cnt_d = cnt_q + 1'b1;
                commit = (cnt_q == CW'(DEBOUNCE_FRAMES - 1));
            end else begin
                cnt_d = '0;
            end
        end
        if (commit) begin
            unique case (1'b1)
                (ones == 5'd0): state_d = ST_RELEASED;
                (ones == 5'd1): begin
                    state_d  = ST_HELD;
                    key_d    = code;
                    strobe_d = (state_q != ST_HELD) || (code != key_q);
                end
                (ones > 5'd1):  state_d = ST_MULTI;
            endcase
        end
    end

    assign key        = key_q;
    assign key_strobe = strobe_q;
    assign key_valid  = (state_q == ST_HELD);
    assign multi      = (state_q == ST_MULTI);

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 keypad scanner: row synchronizer, column dwell/scan and frame
// snapshot, feeding the frame debouncer.
module hex_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       CLK100MHZ,
    input  logic       RST,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY,
    output logic       KEY_VALID,
    output logic       KEY_STROBE,
    output logic       MULTI
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0]      dwell;
    logic [1:0]         col_idx;
    logic [3:0]         row_meta;
    logic [3:0]         row_sync;
    logic [FRAME_W-1:0] snap;
    logic [FRAME_W-1:0] frame;
    logic               sample;
    logic               frame_end;

    assign sample    = (dwell == DW'(SCAN_DIV - 1));
    assign frame_end = sample && (col_idx == 2'd3);

    // Snapshot with the current column's pressed rows merged in.
    always_comb begin
        frame = snap;
        for (int r = 0; r < 4; r++) begin
            frame[r*4 + int'(col_idx)] = ~row_sync[r];
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            row_meta <= 4'h0;
            row_sync <= 4'h0;
            dwell    <= '0;
            col_idx  <= 2'd0;
            snap     <= '0;
        end else begin
            row_meta <= ROW;
            row_sync <= row_meta;
            if (sample) begin
                snap    <= frame;
                dwell   <= '0;
                col_idx <= col_idx + 2'd1;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    assign COL = COL_SEL[col_idx];

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (CLK100MHZ),
        .rst        (RST),
        .frame_end  (frame_end),
        .frame      (frame),
        .key        (KEY),
        .key_valid  (KEY_VALID),
        .key_strobe (KEY_STROBE),
        .multi      (MULTI)
    );

endmodule
